// File: rtl/master_control.sv
// Transmit-side handshake controller for the Chip2Chip link.
// A send pulse captures data_in and starts a request/ack/valid sequence
// toward the slave-side control block. The asynchronous ack is
// synchronised before use, and a single counter serves both the
// valid-hold length and the wait timeout.
module master_control #(
  parameter int DATA_W         = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int VALID_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 500000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ack,
  output logic              request,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              notice,
  output logic              busy,
  output logic              timeout
);

  localparam int MAX_CYCLES = (VALID_CYCLES > TIMEOUT_CYCLES) ? VALID_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] VALID_LAST   = CNT_W'(VALID_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKED = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   abort;
  logic [DATA_W-1:0]      data_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [DATA_W-1:0]      data_reg;
  logic [CNT_W-1:0]       cnt;

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // Shift the asynchronous ack through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every clocked register uses <= so all flops update from the
    // values present before the edge, independent of statement order.
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
    end
  end

  // Next-state decode; ack transitions take priority over the timeout.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no
    // latch is inferred.
    state_nxt = state;
    abort     = 1'b0;
    data_nxt  = data_reg;
    case (state)
      IDLE: begin
        data_nxt = data_in;
        if (send) state_nxt = REQ;
      end
      REQ: begin
        if (ack_s) begin
          state_nxt = ACKED;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      ACKED: begin
        if (!ack_s) begin
          state_nxt = SEND;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      SEND: begin
        if (cnt == VALID_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, captured data and registered outputs, all decoded
  // from the next state so outputs move on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      data_reg <= '0;
      request  <= 1'b0;
      data_out <= '0;
      valid    <= 1'b0;
      notice   <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || (state == IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if ((state == IDLE) && send) data_reg <= data_in;
      request  <= (state_nxt == REQ);
      valid    <= (state_nxt == SEND);
      notice   <= (state_nxt == REQ) || (state_nxt == ACKED);
      busy     <= (state_nxt != IDLE);
      timeout  <= abort;
      data_out <= (state_nxt == IDLE) ? '0 : data_nxt;
    end
  end

endmodule

// File: tb/tb_master_control.sv
// Scoreboard bench for master_control. Two instances share clk/rst_n:
// dut_a (VALID_CYCLES=4, long timeout) for normal transfers and
// dut_b (VALID_CYCLES=4, TIMEOUT_CYCLES=10) for abort cases. Stimulus
// queues the expected output snapshot and posedge number of every output
// change; a monitor pops one entry whenever an instance's outputs change.
// Output snapshot bit order: {request, valid, notice, busy, timeout, data_out}.
module tb_master_control;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  o;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       send_a, send_b, ack_a, ack_b;
  logic [2:0] data_in_a, data_in_b, data_out_a, data_out_b;
  logic       request_a, valid_a, notice_a, busy_a, timeout_a;
  logic       request_b, valid_b, notice_b, busy_b, timeout_b;

  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q [2][$];
  logic [7:0] prev_o [2];
  exp_t drain_e;

  master_control #(.DATA_W(3), .SYNC_STAGES(2), .VALID_CYCLES(4), .TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .send(send_a), .data_in(data_in_a), .ack(ack_a),
    .request(request_a), .data_out(data_out_a), .valid(valid_a),
    .notice(notice_a), .busy(busy_a), .timeout(timeout_a)
  );

  master_control #(.DATA_W(3), .SYNC_STAGES(2), .VALID_CYCLES(4), .TIMEOUT_CYCLES(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .send(send_b), .data_in(data_in_b), .ack(ack_b),
    .request(request_b), .data_out(data_out_b), .valid(valid_b),
    .notice(notice_b), .busy(busy_b), .timeout(timeout_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mk(input logic req, input logic vld, input logic ntc,
                                    input logic bsy, input logic to, input logic [2:0] d);
    return {req, vld, ntc, bsy, to, d};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic expect_out(input int idx, input int at, input logic [7:0] o);
    exp_t e;
    e.cyc = 32'(at);
    e.o   = o;
    exp_q[idx].push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic mon_step(input int idx, input logic [7:0] cur);
    exp_t e;
    if (cur !== prev_o[idx]) begin
      checks++;
      if (exp_q[idx].size() == 0) begin
        errors++;
        $display("FAIL unexpected_change dut%0d cyc=%0d got=%b want=no change", idx, cyc, cur);
      end else begin
        e = exp_q[idx].pop_front();
        if ((e.cyc != 32'(cyc)) || (e.o !== cur)) begin
          errors++;
          $display("FAIL output_change dut%0d got=%b@%0d want=%b@%0d", idx, cur, cyc, e.o, e.cyc);
        end
      end
      prev_o[idx] = cur;
    end
  endtask

  // Monitor: compare every output change of each instance against the queue.
  always @(negedge clk) begin
    mon_step(0, {request_a, valid_a, notice_a, busy_a, timeout_a, data_out_a});
    mon_step(1, {request_b, valid_b, notice_b, busy_b, timeout_b, data_out_b});
  end

  initial begin
    int c0, ca, co, c2, c3, s, cs, cf, cr, cb, cb2, cb3;
    prev_o[0] = '0;
    prev_o[1] = '0;
    rst_n = 1'b0;
    send_a = 1'b0; send_b = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
    data_in_a = 3'b000; data_in_b = 3'b000;
    repeat (2) @(negedge clk);
    check("reset_a", {24'b0, request_a, valid_a, notice_a, busy_a, timeout_a, data_out_a}, 32'h0);
    check("reset_b", {24'b0, request_b, valid_b, notice_b, busy_b, timeout_b, data_out_b}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal transfer with data_in changing after capture, plus sends while busy.
    c0 = cyc; send_a = 1'b1; data_in_a = 3'b101;
    expect_out(0, c0 + 1, mk(1, 0, 1, 1, 0, 3'b101));
    @(negedge clk); send_a = 1'b0; data_in_a = 3'b010;
    wait_until(c0 + 5); send_a = 1'b1; data_in_a = 3'b111;
    @(negedge clk); send_a = 1'b0; data_in_a = 3'b010;
    wait_until(c0 + 21); ca = cyc; ack_a = 1'b1;
    expect_out(0, ca + 3, mk(0, 0, 1, 1, 0, 3'b101));
    wait_until(ca + 50); co = cyc; ack_a = 1'b0;
    expect_out(0, co + 3, mk(0, 1, 0, 1, 0, 3'b101));
    expect_out(0, co + 7, mk(0, 0, 0, 0, 0, 3'b000));
    wait_until(co + 4); send_a = 1'b1;
    @(negedge clk); send_a = 1'b0;
    // Send sampled on the return-to-IDLE edge is dropped; one cycle later it starts a transfer.
    wait_until(co + 6); send_a = 1'b1;
    @(negedge clk); data_in_a = 3'b011;
    expect_out(0, co + 8, mk(1, 0, 1, 1, 0, 3'b011));
    @(negedge clk); send_a = 1'b0;
    wait_until(co + 10); c2 = cyc; ack_a = 1'b1;
    expect_out(0, c2 + 3, mk(0, 0, 1, 1, 0, 3'b011));
    wait_until(c2 + 8); c3 = cyc; ack_a = 1'b0;
    expect_out(0, c3 + 3, mk(0, 1, 0, 1, 0, 3'b011));
    expect_out(0, c3 + 7, mk(0, 0, 0, 0, 0, 3'b000));
    wait_until(c3 + 9);

    // Stale ack: ack_s already high when REQ is entered.
    s = cyc; ack_a = 1'b1;
    wait_until(s + 4); cs = cyc; send_a = 1'b1; data_in_a = 3'b001;
    expect_out(0, cs + 1, mk(1, 0, 1, 1, 0, 3'b001));
    expect_out(0, cs + 2, mk(0, 0, 1, 1, 0, 3'b001));
    @(negedge clk); send_a = 1'b0;
    wait_until(cs + 3); cf = cyc; ack_a = 1'b0;
    expect_out(0, cf + 3, mk(0, 1, 0, 1, 0, 3'b001));
    expect_out(0, cf + 7, mk(0, 0, 0, 0, 0, 3'b000));
    wait_until(cf + 9);

    // Asynchronous reset in the middle of SEND.
    cr = cyc; send_a = 1'b1; data_in_a = 3'b100;
    expect_out(0, cr + 1, mk(1, 0, 1, 1, 0, 3'b100));
    @(negedge clk); send_a = 1'b0; ack_a = 1'b1;
    expect_out(0, cr + 4, mk(0, 0, 1, 1, 0, 3'b100));
    wait_until(cr + 6); ack_a = 1'b0;
    expect_out(0, cr + 9, mk(0, 1, 0, 1, 0, 3'b100));
    wait_until(cr + 10);
    expect_out(0, cr + 11, mk(0, 0, 0, 0, 0, 3'b000));
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("async_reset_a", {24'b0, request_a, valid_a, notice_a, busy_a, timeout_a, data_out_a}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy_a", {31'b0, busy_a}, 32'h0);
    check("post_reset_out_a", {24'b0, request_a, valid_a, notice_a, busy_a, timeout_a, data_out_a}, 32'h0);

    // Timeout in REQ: request high exactly 10 cycles, then a one-cycle timeout.
    cb = cyc; send_b = 1'b1; data_in_b = 3'b110;
    expect_out(1, cb + 1, mk(1, 0, 1, 1, 0, 3'b110));
    expect_out(1, cb + 11, mk(0, 0, 0, 0, 1, 3'b000));
    expect_out(1, cb + 12, mk(0, 0, 0, 0, 0, 3'b000));
    @(negedge clk); send_b = 1'b0;
    wait_until(cb + 14);

    // Stuck ack: abort from ACKED after 10 cycles.
    cb2 = cyc; send_b = 1'b1; data_in_b = 3'b101;
    expect_out(1, cb2 + 1, mk(1, 0, 1, 1, 0, 3'b101));
    @(negedge clk); send_b = 1'b0; ack_b = 1'b1;
    expect_out(1, cb2 + 4, mk(0, 0, 1, 1, 0, 3'b101));
    expect_out(1, cb2 + 14, mk(0, 0, 0, 0, 1, 3'b000));
    expect_out(1, cb2 + 15, mk(0, 0, 0, 0, 0, 3'b000));
    wait_until(cb2 + 18); ack_b = 1'b0;
    wait_until(cb2 + 22);

    // ack_s rises on the same edge the REQ timeout would fire: ack wins.
    cb3 = cyc; send_b = 1'b1; data_in_b = 3'b011;
    expect_out(1, cb3 + 1, mk(1, 0, 1, 1, 0, 3'b011));
    @(negedge clk); send_b = 1'b0;
    wait_until(cb3 + 8); ack_b = 1'b1;
    expect_out(1, cb3 + 11, mk(0, 0, 1, 1, 0, 3'b011));
    wait_until(cb3 + 12); ack_b = 1'b0;
    expect_out(1, cb3 + 15, mk(0, 1, 0, 1, 0, 3'b011));
    expect_out(1, cb3 + 19, mk(0, 0, 0, 0, 0, 3'b000));
    wait_until(cb3 + 24);

    // Any expected change that never appeared is a failure.
    for (int i = 0; i < 2; i++) begin
      while (exp_q[i].size() > 0) begin
        drain_e = exp_q[i].pop_front();
        checks++;
        errors++;
        $display("FAIL missing_change dut%0d got=none want=%b@%0d", i, drain_e.o, drain_e.cyc);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
